// File: rtl/alu_exec_unit_pkg.sv
// Shared definitions for the integer execution unit: opcode codes, rename
// sentinel, data/address widths and boolean constants.
package alu_exec_unit_pkg;

    localparam int DATALEN = 32;
    localparam int ADDR_W  = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    // Tag value meaning "no rename"; the unit never produces it itself.
    localparam logic [4:0] ROBNOTRENAME = 5'd16;

    localparam logic [5:0] OP_ADD   = 6'd1;
    localparam logic [5:0] OP_SUB   = 6'd2;
    localparam logic [5:0] OP_AND   = 6'd3;
    localparam logic [5:0] OP_OR    = 6'd4;
    localparam logic [5:0] OP_XOR   = 6'd5;
    localparam logic [5:0] OP_SLL   = 6'd6;
    localparam logic [5:0] OP_SRL   = 6'd7;
    localparam logic [5:0] OP_SRA   = 6'd8;
    localparam logic [5:0] OP_SLT   = 6'd9;
    localparam logic [5:0] OP_SLTU  = 6'd10;
    localparam logic [5:0] OP_ADDI  = 6'd11;
    localparam logic [5:0] OP_ANDI  = 6'd12;
    localparam logic [5:0] OP_ORI   = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_SLLI  = 6'd15;
    localparam logic [5:0] OP_SRLI  = 6'd16;
    localparam logic [5:0] OP_SRAI  = 6'd17;
    localparam logic [5:0] OP_SLTI  = 6'd18;
    localparam logic [5:0] OP_SLTIU = 6'd19;
    localparam logic [5:0] OP_LUI   = 6'd20;
    localparam logic [5:0] OP_AUIPC = 6'd21;
    localparam logic [5:0] OP_JAL   = 6'd22;
    localparam logic [5:0] OP_JALR  = 6'd23;
    localparam logic [5:0] OP_BEQ   = 6'd24;
    localparam logic [5:0] OP_BNE   = 6'd25;
    localparam logic [5:0] OP_BLT   = 6'd26;
    localparam logic [5:0] OP_BGE   = 6'd27;
    localparam logic [5:0] OP_BLTU  = 6'd28;
    localparam logic [5:0] OP_BGEU  = 6'd29;

endpackage

// File: rtl/alu_exec_unit_compute.sv
// alu_compute: combinational RV32I ALU / branch / jump evaluation.
// Ports: op, a (rs1), b (rs2), imm, pc -> value, is_jump, taken, target.
// Operand B is replaced by imm for the *I forms.
module alu_compute
    import alu_exec_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [5:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [31:0]       imm,
    input  logic [31:0]       pc,
    output logic [DATA_W-1:0] value,
    output logic              is_jump,
    output logic              taken,
    output logic [31:0]       target
);

    logic [31:0] ra, rb, ob, res, pc4, pc_imm;
    logic        is_imm, cond;

    always_comb begin
        ra     = 32'(a);
        rb     = 32'(b);
        pc4    = pc + 32'd4;
        pc_imm = pc + imm;
        is_imm = (op == OP_ADDI) || (op == OP_ANDI) || (op == OP_ORI)  ||
                 (op == OP_XORI) || (op == OP_SLLI) || (op == OP_SRLI) ||
                 (op == OP_SRAI) || (op == OP_SLTI) || (op == OP_SLTIU);
        ob     = is_imm ? imm : rb;

        res     = '0;
        is_jump = FALSE;
        cond    = FALSE;
        target  = '0;
        case (op)
            OP_ADD, OP_ADDI:  res = ra + ob;
            OP_SUB:           res = ra - ob;
            OP_AND, OP_ANDI:  res = ra & ob;
            OP_OR,  OP_ORI:   res = ra | ob;
            OP_XOR, OP_XORI:  res = ra ^ ob;
            OP_SLL, OP_SLLI:  res = ra << ob[4:0];
            OP_SRL, OP_SRLI:  res = ra >> ob[4:0];
            OP_SRA, OP_SRAI:  res = $unsigned($signed(ra) >>> ob[4:0]);
            OP_SLT, OP_SLTI:  res = {31'd0, $signed(ra) < $signed(ob)};
            OP_SLTU, OP_SLTIU: res = {31'd0, ra < ob};
            OP_LUI:           res = imm;
            OP_AUIPC:         res = pc_imm;
            OP_JAL: begin
                res = pc4; is_jump = TRUE; cond = TRUE; target = pc_imm;
            end
            OP_JALR: begin
                res = pc4; is_jump = TRUE; cond = TRUE;
                target = (ra + imm) & ~32'd1;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                is_jump = TRUE;
                case (op)
                    OP_BEQ:  cond = (ra == rb);
                    OP_BNE:  cond = (ra != rb);
                    OP_BLT:  cond = ($signed(ra) <  $signed(rb));
                    OP_BGE:  cond = ($signed(ra) >= $signed(rb));
                    OP_BLTU: cond = (ra <  rb);
                    default: cond = (ra >= rb);
                endcase
                target = cond ? pc_imm : pc4;
            end
            default: ;  // unknown op: zero result, not a jump
        endcase
        value = DATA_W'(res);
        taken = cond;
    end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: integer execution unit. Computes one issued op per cycle and
// holds results in a small circular queue presented on the ALU CDB channel
// until granted.
// Ports: clk/rst (sync, active-high), rdy (global freeze), jump_wrong (flush),
// issue inputs to_alu_*, alu_ready back-pressure, cdb_grant, head outputs
// alu_broadcast/alu_cbd_value/alu_update_rename/alu_is_jump/alu_jump_taken/
// alu_jump_target, and sticky err_overflow.
module alu_exec_unit
    import alu_exec_unit_pkg::*;
#(
    parameter int ROB_IDX_W = 5,
    parameter int DATA_W    = 32,
    parameter int Q_DEPTH   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 jump_wrong,
    input  logic                 alu_enable,
    input  logic [5:0]           to_alu_op,
    input  logic [DATA_W-1:0]    to_alu_rs1_value,
    input  logic [DATA_W-1:0]    to_alu_rs2_value,
    input  logic [31:0]          to_alu_imm,
    input  logic [31:0]          to_alu_pc,
    input  logic [ROB_IDX_W-1:0] to_alu_rd_renaming,
    output logic                 alu_ready,
    input  logic                 cdb_grant,
    output logic                 alu_broadcast,
    output logic [DATA_W-1:0]    alu_cbd_value,
    output logic [ROB_IDX_W-1:0] alu_update_rename,
    output logic                 alu_is_jump,
    output logic                 alu_jump_taken,
    output logic [31:0]          alu_jump_target,
    output logic                 err_overflow
);

    localparam int CNT_W = $clog2(Q_DEPTH + 1);
    localparam int PTR_W = (Q_DEPTH > 1) ? $clog2(Q_DEPTH) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(Q_DEPTH);
    localparam logic [PTR_W-1:0] LAST_C  = PTR_W'(Q_DEPTH - 1);

    logic [DATA_W-1:0]    q_value  [Q_DEPTH];
    logic [ROB_IDX_W-1:0] q_tag    [Q_DEPTH];
    logic                 q_jump   [Q_DEPTH];
    logic                 q_taken  [Q_DEPTH];
    logic [31:0]          q_target [Q_DEPTH];

    logic [PTR_W-1:0] head, tail;
    logic [CNT_W-1:0] count;

    logic [DATA_W-1:0] c_value;
    logic              c_jump, c_taken;
    logic [31:0]       c_target;
    logic              push, pop;

    alu_compute #(.DATA_W(DATA_W)) u_compute (
        .op      (to_alu_op),
        .a       (to_alu_rs1_value),
        .b       (to_alu_rs2_value),
        .imm     (to_alu_imm),
        .pc      (to_alu_pc),
        .value   (c_value),
        .is_jump (c_jump),
        .taken   (c_taken),
        .target  (c_target)
    );

    // Ready comes only from the registered count so the RS never sees a
    // combinational path from the CDB arbiter.
    assign alu_ready     = (count < DEPTH_C);
    assign alu_broadcast = (count != '0);
    assign push          = alu_enable & rdy & alu_ready;
    assign pop           = alu_broadcast & cdb_grant & rdy;

    // Entries are zeroed on reset/flush so the raw head fields read 0 then.
    assign alu_cbd_value     = q_value[head];
    assign alu_update_rename = q_tag[head];
    assign alu_jump_target   = q_target[head];
    assign alu_is_jump       = alu_broadcast & q_jump[head];
    assign alu_jump_taken    = alu_broadcast & q_taken[head];

    always_ff @(posedge clk) begin
        if (rst || jump_wrong) begin
            for (int i = 0; i < Q_DEPTH; i++) begin
                q_value[i]  <= '0;
                q_tag[i]    <= '0;
                q_jump[i]   <= FALSE;
                q_taken[i]  <= FALSE;
                q_target[i] <= '0;
            end
            head  <= '0;
            tail  <= '0;
            count <= '0;
            if (rst) err_overflow <= FALSE;
        end else if (rdy) begin
            if (push) begin
                q_value[tail]  <= c_value;
                q_tag[tail]    <= to_alu_rd_renaming;
                q_jump[tail]   <= c_jump;
                q_taken[tail]  <= c_taken;
                q_target[tail] <= c_target;
                tail <= (tail == LAST_C) ? '0 : tail + 1'b1;
            end
            if (pop) head <= (head == LAST_C) ? '0 : head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
            if (alu_enable && !alu_ready) err_overflow <= TRUE;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit: directed cases plus randomized traffic,
// checked by a scoreboard queue fed by the driver and drained by a monitor.
module tb_alu_exec_unit;
    import alu_exec_unit_pkg::*;

    localparam int QD = 2;

    logic        clk = 0, rst = 1, rdy = 1, jump_wrong = 0, alu_enable = 0;
    logic [5:0]  to_alu_op = 0;
    logic [31:0] to_alu_rs1_value = 0, to_alu_rs2_value = 0, to_alu_imm = 0, to_alu_pc = 0;
    logic [4:0]  to_alu_rd_renaming = 0;
    logic        cdb_grant = 0;
    logic        alu_ready, alu_broadcast, alu_is_jump, alu_jump_taken, err_overflow;
    logic [31:0] alu_cbd_value, alu_jump_target;
    logic [4:0]  alu_update_rename;

    alu_exec_unit #(.ROB_IDX_W(5), .DATA_W(32), .Q_DEPTH(QD)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
        .alu_enable(alu_enable), .to_alu_op(to_alu_op),
        .to_alu_rs1_value(to_alu_rs1_value), .to_alu_rs2_value(to_alu_rs2_value),
        .to_alu_imm(to_alu_imm), .to_alu_pc(to_alu_pc),
        .to_alu_rd_renaming(to_alu_rd_renaming), .alu_ready(alu_ready),
        .cdb_grant(cdb_grant), .alu_broadcast(alu_broadcast),
        .alu_cbd_value(alu_cbd_value), .alu_update_rename(alu_update_rename),
        .alu_is_jump(alu_is_jump), .alu_jump_taken(alu_jump_taken),
        .alu_jump_target(alu_jump_target), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] value;
        logic [4:0]  tag;
        logic        is_jump;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    exp_t exp_q[$];
    logic exp_err = 0;
    bit   mon_on = 0;
    int   n_chk = 0, n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // Reference model straight from the ISA rules.
    function automatic exp_t model(input logic [5:0] op, input logic [31:0] a, b, imm, pc);
        exp_t e;
        int signed sa, sb, si;
        e = '{value: 0, tag: 0, is_jump: 0, taken: 0, target: 0};
        sa = a; sb = b; si = imm;
        case (op)
            OP_ADD:   e.value = a + b;
            OP_SUB:   e.value = a - b;
            OP_AND:   e.value = a & b;
            OP_OR:    e.value = a | b;
            OP_XOR:   e.value = a ^ b;
            OP_SLL:   e.value = a << (b % 32);
            OP_SRL:   e.value = a >> (b % 32);
            OP_SRA:   e.value = sa >>> (b % 32);
            OP_SLT:   e.value = (sa < sb) ? 1 : 0;
            OP_SLTU:  e.value = (a < b) ? 1 : 0;
            OP_ADDI:  e.value = a + imm;
            OP_ANDI:  e.value = a & imm;
            OP_ORI:   e.value = a | imm;
            OP_XORI:  e.value = a ^ imm;
            OP_SLLI:  e.value = a << (imm % 32);
            OP_SRLI:  e.value = a >> (imm % 32);
            OP_SRAI:  e.value = sa >>> (imm % 32);
            OP_SLTI:  e.value = (sa < si) ? 1 : 0;
            OP_SLTIU: e.value = (a < imm) ? 1 : 0;
            OP_LUI:   e.value = imm;
            OP_AUIPC: e.value = pc + imm;
            OP_JAL:  begin e.value = pc + 4; e.is_jump = 1; e.taken = 1; e.target = pc + imm; end
            OP_JALR: begin e.value = pc + 4; e.is_jump = 1; e.taken = 1; e.target = (a + imm) & 32'hFFFF_FFFE; end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                e.is_jump = 1;
                if (op == OP_BEQ)  e.taken = (a == b);
                if (op == OP_BNE)  e.taken = (a != b);
                if (op == OP_BLT)  e.taken = (sa < sb);
                if (op == OP_BGE)  e.taken = !(sa < sb);
                if (op == OP_BLTU) e.taken = (a < b);
                if (op == OP_BGEU) e.taken = !(a < b);
                e.target = e.taken ? pc + imm : pc + 4;
            end
            default: ;
        endcase
        return e;
    endfunction

    // One cycle of stimulus; the scoreboard is updated after the edge so it
    // tracks the DUT count at each negedge.
    task automatic step(input logic en, input logic [5:0] op, input logic [31:0] a, b, imm, pc,
                        input logic [4:0] tag, input logic gnt, input logic rd, input logic jw);
        exp_t e;
        bit acc, ovf;
        alu_enable = en; to_alu_op = op; to_alu_rs1_value = a; to_alu_rs2_value = b;
        to_alu_imm = imm; to_alu_pc = pc; to_alu_rd_renaming = tag;
        cdb_grant = gnt; rdy = rd; jump_wrong = jw;
        acc = en && rd && !jw && (exp_q.size() < QD);
        ovf = en && rd && !jw && (exp_q.size() >= QD);
        e = model(op, a, b, imm, pc);
        e.tag = tag;
        @(posedge clk); #1;
        if (jw) exp_q.delete();
        else if (acc) exp_q.push_back(e);
        if (ovf) exp_err = 1;
        alu_enable = 0; jump_wrong = 0;
    endtask

    task automatic idle(input logic gnt);
        step(0, 6'd0, 0, 0, 0, 0, 0, gnt, 1, 0);
    endtask

    // Monitor: compares the presented head with the scoreboard and pops on grant.
    always @(negedge clk) begin
        if (mon_on) begin
            check("ready", alu_ready, (exp_q.size() < QD));
            check("broadcast", alu_broadcast, (exp_q.size() > 0));
            check("err_overflow", err_overflow, exp_err);
            if (exp_q.size() > 0 && alu_broadcast) begin
                check("value", alu_cbd_value, exp_q[0].value);
                check("tag", alu_update_rename, exp_q[0].tag);
                check("is_jump", alu_is_jump, exp_q[0].is_jump);
                check("taken", alu_jump_taken, exp_q[0].taken);
                check("target", alu_jump_target, exp_q[0].target);
                if (cdb_grant && rdy) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        check("rst broadcast", alu_broadcast, 0);
        check("rst ready", alu_ready, 1);
        check("rst value", alu_cbd_value, 0);
        check("rst tag", alu_update_rename, 0);
        check("rst target", alu_jump_target, 0);
        check("rst err", err_overflow, 0);
        check("rst is_jump", alu_is_jump, 0);
        mon_on = 1;

        // basic latency
        step(1, OP_ADD, 5, 7, 0, 0, 3, 1, 1, 0);
        check("add bcast t+1", alu_broadcast, 1);
        check("add value", alu_cbd_value, 12);
        check("add tag", alu_update_rename, 3);
        idle(1);
        check("add bcast t+2", alu_broadcast, 0);

        // shifts and compares
        step(1, OP_SRAI, 32'h8000_0000, 0, 4, 0, 1, 1, 1, 0);
        check("srai value", alu_cbd_value, 32'hF800_0000);
        step(1, OP_SLTU, 1, 32'hFFFF_FFFF, 0, 0, 2, 1, 1, 0);
        check("sltu value", alu_cbd_value, 1);
        step(1, OP_SLT, 1, 32'hFFFF_FFFF, 0, 0, 4, 1, 1, 0);
        check("slt value", alu_cbd_value, 0);

        // branches and jalr
        step(1, OP_BLT, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 5, 1, 1, 0);
        check("blt is_jump", alu_is_jump, 1);
        check("blt taken", alu_jump_taken, 1);
        check("blt target", alu_jump_target, 32'h120);
        step(1, OP_BGEU, 32'hFFFF_FFFF, 1, 32'h20, 32'h100, 6, 1, 1, 0);
        check("bgeu taken", alu_jump_taken, 1);
        check("bgeu target", alu_jump_target, 32'h120);
        step(1, OP_JALR, 32'h1003, 0, 4, 32'h40, 7, 1, 1, 0);
        check("jalr value", alu_cbd_value, 32'h44);
        check("jalr target", alu_jump_target, 32'h1006);
        idle(1);

        // back-pressure, hold and overflow
        step(1, OP_ADD, 1, 2, 0, 0, 8, 0, 1, 0);
        step(1, OP_SUB, 9, 4, 0, 0, 9, 0, 1, 0);
        check("full ready", alu_ready, 0);
        check("full head", alu_cbd_value, 3);
        step(1, OP_XOR, 3, 5, 0, 0, 10, 0, 1, 0);
        check("ovf err", err_overflow, 1);
        check("ovf head held", alu_cbd_value, 3);
        check("ovf head tag", alu_update_rename, 8);
        repeat (3) idle(1);
        check("drained", alu_broadcast, 0);

        // flush with simultaneous enable
        step(1, OP_OR, 1, 2, 0, 0, 11, 0, 1, 0);
        step(1, OP_AND, 3, 6, 0, 0, 12, 0, 1, 0);
        step(1, OP_ADD, 1, 1, 0, 0, 13, 0, 1, 1);
        check("flush bcast", alu_broadcast, 0);
        check("flush ready", alu_ready, 1);
        check("flush err kept", err_overflow, 1);
        check("flush value", alu_cbd_value, 0);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 4) != 0, 6'($urandom_range(0, 35)), $urandom, $urandom,
                 (($urandom % 2) != 0) ? $urandom : 32'($urandom % 64), $urandom, 5'($urandom % 16),
                 ($urandom % 3) != 0, ($urandom % 8) != 0, ($urandom % 40) == 0);
        end
        repeat (4) idle(1);
        check("final empty", 32'(exp_q.size()), 0);
        mon_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
